// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches and decodes instruction words, then dispatches each one
// to a per-opcode execution unit and retires it when the unit reports done.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | program memory read issued
// LOAD   | memory data valid, IR captures it
// DECODE | opcode checked for halt / legality
// EXEC   | unit enabled and granted the bus, waiting for done or timeout
// GAP    | one dead cycle so the unit returns to idle before the next grant
// HALT   | HALT opcode seen, parked until run drops
// FAULT  | illegal opcode or hung unit, parked until clearFault
module instr_sequencer #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] VALID_OPS = 16'h00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clearFault,
  input  logic [15:0] memData,
  input  logic [15:0] unitDone,
  output logic        memRd,
  output logic        irLoad,
  output logic [15:0] instruction,
  output logic [15:0] unitEn,
  output logic [15:0] busGrant,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  faultCode,
  output logic [15:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [3:0] OP_HALT   = 4'hF;
  // Timer starts at 0 on EXEC entry, so the last allowed EXEC cycle sees TIMEOUT-1.
  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;
  logic [3:0]  timer;
  logic [15:0] ret_cnt;
  logic [1:0]  fault_code;
  logic [3:0]  op;
  logic        op_done;
  logic        op_illegal;
  logic        timed_out;

  assign op         = ir[15:12];
  assign op_done    = unitDone[op];
  assign op_illegal = (op != OP_HALT) && !VALID_OPS[op];
  assign timed_out  = (timer == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT)  state_nxt = S_HALT;
        else if (op_illegal) state_nxt = S_FAULT;
        else                 state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (op_done)        state_nxt = S_GAP;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_GAP:    state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   if (!run) state_nxt = S_IDLE;
      S_FAULT:  if (clearFault) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ir         <= 16'h0000;
      timer      <= 4'd0;
      ret_cnt    <= 16'h0000;
      fault_code <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) ir <= memData;
      if (state == S_DECODE)    timer <= 4'd0;
      else if (state == S_EXEC) timer <= timer + 4'd1;
      if (state == S_EXEC && op_done) ret_cnt <= ret_cnt + 16'd1;
      if (state == S_DECODE && op_illegal)               fault_code <= 2'b01;
      else if (state == S_EXEC && !op_done && timed_out) fault_code <= 2'b10;
      else if (state == S_FAULT && clearFault)           fault_code <= 2'b00;
    end
  end

  // Enables and grants decode from registered state only, so reset drops them at once.
  assign unitEn      = (state == S_EXEC) ? (16'd1 << op) : 16'h0000;
  assign busGrant    = unitEn;
  assign memRd       = (state == S_FETCH) || (state == S_LOAD);
  assign irLoad      = (state == S_LOAD);
  assign instruction = ir;
  assign busy        = !((state == S_IDLE) || (state == S_HALT) || (state == S_FAULT));
  assign halted      = (state == S_HALT);
  assign fault       = (state == S_FAULT);
  assign faultCode   = fault_code;
  assign retired     = ret_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: records a per-cycle trace of the outputs while a
// behavioural unit model answers enables, then checks the trace against hand-derived values.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        clearFault;
  logic [15:0] memData;
  logic [15:0] unitDone;
  logic        memRd;
  logic        irLoad;
  logic [15:0] instruction;
  logic [15:0] unitEn;
  logic [15:0] busGrant;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [1:0]  faultCode;
  logic [15:0] retired;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .clearFault(clearFault),
    .memData(memData), .unitDone(unitDone),
    .memRd(memRd), .irLoad(irLoad), .instruction(instruction),
    .unitEn(unitEn), .busGrant(busGrant), .busy(busy), .halted(halted),
    .fault(fault), .faultCode(faultCode), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        ld;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fc;
    logic [15:0] en;
    logic [15:0] gr;
    logic [15:0] ir;
    logic [15:0] ret;
  } snap_t;

  snap_t       tr [0:63];
  logic [15:0] prog [0:3];
  int          pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_en(input int lo, input int hi, input logic [15:0] val);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (tr[i].en == val) c++;
    return c;
  endfunction

  function automatic int count_gr(input int lo, input int hi, input logic [15:0] val);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (tr[i].gr == val) c++;
    return c;
  endfunction

  function automatic int count_rd(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (tr[i].rd) c++;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; clearFault = 1'b0; unitDone = 16'h0; memData = 16'h0; pc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Unit model: done on the done_at-th consecutive enabled cycle (0 = never).
  task automatic trace(input int n, input int done_at, input int run_off_at,
                       input int clear_at, input int stray_at, input logic [15:0] stray);
    int en_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr[i] = '{rd: memRd, ld: irLoad, busy: busy, halted: halted, fault: fault,
                fc: faultCode, en: unitEn, gr: busGrant, ir: instruction, ret: retired};
      if (memRd && !irLoad) begin
        memData = prog[pc % 4];
        pc++;
      end
      en_cnt   = (unitEn != 16'h0) ? en_cnt + 1 : 0;
      unitDone = ((done_at != 0 && en_cnt == done_at) ? unitEn : 16'h0) |
                 ((i == stray_at) ? stray : 16'h0);
      if (i == run_off_at) run = 1'b0;
      clearFault = (i == clear_at);
    end
    unitDone   = 16'h0;
    clearFault = 1'b0;
  endtask

  initial begin
    int f1;
    int f2;
    rst = 1'b1; run = 1'b0; clearFault = 1'b0; unitDone = 16'h0; memData = 16'h0; pc = 0;
    #12;
    check("rst_strobes", {31'h0, memRd | irLoad | busy | halted | fault}, 32'h0);
    check("rst_en_gr", {unitEn, busGrant}, 32'h0);
    check("rst_ir_ret", {instruction, retired}, 32'h0);
    check("rst_fc", {30'h0, faultCode}, 32'h0);

    // MOVi profile, stray done on another opcode, run dropped mid-EXEC of the second instr
    do_reset();
    for (int i = 0; i < 4; i++) prog[i] = 16'h5045;
    run = 1'b1;
    trace(20, 4, 13, 0, 12, 16'h0008);
    check("movi_memrd_cycles", count_rd(1, 8), 2);
    check("movi_ir", {16'h0, tr[3].ir}, 32'h5045);
    check("movi_en_cycles", count_en(1, 8, 16'h0020), 4);
    check("movi_gr_cycles", count_gr(1, 8, 16'h0020), 4);
    check("movi_gap_quiet", {tr[8].en, tr[8].gr}, 32'h0);
    check("movi_retired", {16'h0, tr[8].ret}, 1);
    f1 = 0; f2 = 0;
    for (int i = 1; i <= 20; i++)
      if (tr[i].rd && !tr[i].ld) begin
        if (f1 == 0) f1 = i;
        else if (f2 == 0) f2 = i;
      end
    check("movi_fetch_period", f2 - f1, 8);
    check("stray_done_ignored", {16'h0, tr[13].en}, 32'h0020);
    check("runoff_gap", {15'h0, tr[16].busy, tr[16].en}, 32'h10000);
    check("runoff_idle_busy", {31'h0, tr[17].busy}, 0);
    check("runoff_retired", {16'h0, tr[17].ret}, 2);
    check("runoff_no_fetch", count_rd(17, 20), 0);

    // 5xxx, 3xxx, HALT with prompt dones
    do_reset();
    prog[0] = 16'h5000; prog[1] = 16'h3000; prog[2] = 16'hF000; prog[3] = 16'hF000;
    run = 1'b1;
    trace(18, 1, 16, 0, 0, 16'h0);
    check("prog_op3_en", {16'h0, tr[9].en}, 32'h0008);
    check("halt_halted", {31'h0, tr[14].halted}, 1);
    check("halt_busy", {31'h0, tr[14].busy}, 0);
    check("halt_retired", {16'h0, tr[14].ret}, 2);
    check("halt_no_fetch", count_rd(14, 18), 0);
    check("halt_runoff_idle", {30'h0, tr[17].halted, tr[17].busy}, 0);

    // Illegal opcode 9
    do_reset();
    for (int i = 0; i < 4; i++) prog[i] = 16'h9000;
    run = 1'b1;
    trace(12, 1, 8, 10, 0, 16'h0);
    check("illegal_fault", {29'h0, tr[4].fault, tr[4].fc}, 32'h5);
    check("illegal_no_en", count_en(1, 12, 16'h0), 12);
    check("fault_ignores_run", {29'h0, tr[10].fault, tr[10].fc}, 32'h5);
    check("clear_fault", {28'h0, tr[11].fault, tr[11].busy, tr[11].fc}, 0);

    // Hung unit times out after 15 EXEC cycles
    do_reset();
    for (int i = 0; i < 4; i++) prog[i] = 16'h5045;
    run = 1'b1;
    trace(22, 0, 5, 0, 0, 16'h0);
    check("timeout_en_cycles", count_en(1, 22, 16'h0020), 15);
    check("timeout_fault", {29'h0, tr[19].fault, tr[19].fc}, 32'h6);
    check("timeout_en_off", {16'h0, tr[19].en}, 0);

    // Done on the timeout cycle wins
    do_reset();
    run = 1'b1;
    trace(22, 15, 5, 0, 0, 16'h0);
    check("late_done_en_cycles", count_en(1, 22, 16'h0020), 15);
    check("late_done_no_fault", {31'h0, tr[19].fault}, 0);
    check("late_done_retired", {16'h0, tr[19].ret}, 1);
    check("late_done_idle", {31'h0, tr[20].busy}, 0);

    // retired wraps from FFFF to 0
    do_reset();
    @(negedge clk);
    force dut.ret_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.ret_cnt;
    run = 1'b1;
    trace(8, 2, 5, 0, 0, 16'h0);
    check("wrap_preload", {16'h0, tr[1].ret}, 32'hFFFF);
    check("wrap_retired", {16'h0, tr[6].ret}, 0);

    // Asynchronous reset in the middle of EXEC
    do_reset();
    run = 1'b1;
    trace(9, 1, 0, 0, 0, 16'h0);
    check("pre_rst_en", {16'h0, tr[9].en}, 32'h0020);
    check("pre_rst_retired", {16'h0, tr[9].ret}, 1);
    rst = 1'b1;
    #1;
    check("async_rst_en_gr", {unitEn, busGrant}, 0);
    check("async_rst_ir_ret", {instruction, retired}, 0);
    check("async_rst_flags", {25'h0, memRd, irLoad, busy, halted, fault, faultCode}, 0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Top-level instruction sequencer for the microcontroller. It fetches instruction words from program memory, latches them into the instruction register, and decodes the 4-bit opcode. It then enables exactly one per-opcode execution FSM (MOVi and its siblings) and grants that FSM the shared data bus. It waits for the FSM's `done`, retires the instruction, and detects halt, illegal-opcode and hung-unit conditions.

## Interface
- `TIMEOUT`, default 15: maximum EXEC cycles without `done` before a fault; 4-bit counter range 1..15.
- `VALID_OPS`, default 16'h00FF: bit n set means opcode n has an execution FSM; opcode 4'hF is always HALT regardless of mask.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; high = sequence instructions, low = stop at next instruction boundary.
- `clearFault`  in  1  synchronous pulse; leaves FAULT.
- `memData`  in  16  program memory read data, valid the cycle after `memRd` rises.
- `unitDone`  in  16  done pulses from execution FSMs, indexed by opcode.
- `memRd`  out  1  program memory read strobe.
- `irLoad`  out  1  high in the cycle the IR captures `memData`.
- `instruction`  out  16  latched IR, broadcast to all execution FSMs.
- `unitEn`  out  16  one-hot enable of the execution FSM for the current opcode.
- `busGrant`  out  16  one-hot bus grant; only the granted unit may assert its `triEN`.
- `busy`  out  1  high in every state except IDLE, HALT, FAULT.
- `halted`  out  1  high in HALT.
- `fault`  out  1  high in FAULT.
- `faultCode`  out  2  01 illegal opcode, 10 timeout, 00 none.
- `retired`  out  16  count of completed instructions.

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXEC, GAP, HALT, FAULT.
- IDLE: all strobes low. Goes to FETCH when `run`=1.
- FETCH: `memRd`=1. Goes to LOAD.
- LOAD: `memRd`=1, `irLoad`=1. IR <= `memData` at the end of the cycle. Goes to DECODE.
- DECODE: `op`=IR[15:12].
  - op=4'hF: go to HALT.
  - VALID_OPS[op]=0: go to FAULT, `faultCode`=01.
  - Otherwise: go to EXEC with the timer cleared.
- EXEC:
  - `unitEn[op]`=1 and `busGrant[op]`=1; all other bits 0.
  - Timer increments each cycle.
  - `unitDone[op]`=1: go to GAP and increment `retired`.
  - `unitDone` bits for other opcodes are ignored.
  - Timer reaches TIMEOUT with no done: go to FAULT, `faultCode`=10.
  - If done and timeout occur in the same cycle, done wins.
- GAP: all enables and grants 0 for exactly one cycle, so the unit FSM returns to its idle state. Goes to FETCH if `run`=1, else IDLE.
- HALT: `halted`=1, no fetch. Goes to IDLE when `run`=0.
- FAULT:
  - `fault`=1; `faultCode` holds its value.
  - `clearFault`=1: go to IDLE and set `faultCode` to 00.
  - `run` has no effect in FAULT.
- `run` falling mid-instruction does not abort the instruction; it is sampled only in IDLE and GAP.
- `retired` wraps from 16'hFFFF to 0.
- IR holds its value outside LOAD; `instruction` is stable throughout DECODE, EXEC and GAP.

## Timing
- Reset value of every output is 0. On reset, IR=0, timer=0, `retired`=0, state=IDLE.
- Reset mid-EXEC drops `unitEn` and `busGrant` asynchronously.
- All outputs are Moore, decoded from registered state and IR; no combinational path from inputs to outputs.
- Overhead is 4 cycles per instruction (FETCH, LOAD, DECODE, GAP) plus EXEC cycles. EXEC cycles equal the cycle count up to and including the one where `unitDone[op]` is seen.
- A unit asserting done on its 4th enabled cycle (MOVi profile) gives 8 cycles per instruction.
- Back-to-back instructions: FETCH follows GAP with no idle cycle while `run`=1.
- `busGrant` is never asserted in GAP, so two units never overlap on the bus.

## Test plan
- Reset, `run`=1, `memData`=16'h5045 (MOVi r1,#5), `unitDone[5]` on the 4th EXEC cycle:
  - `memRd` high for 2 cycles, `instruction`=16'h5045.
  - `unitEn`=`busGrant`=16'h0020 for 4 cycles, then one GAP cycle with both 0.
  - `retired`=1; next FETCH 8 cycles after the first.
- Program 5xxx, 3xxx, F000 with prompt dones:
  - `retired`=2, `halted`=1, `busy`=0, no further `memRd`.
  - `run`=0 returns to IDLE.
- `memData`=16'h9000 (opcode 9, mask bit clear):
  - FAULT with `faultCode`=01 and `unitEn` never asserted.
  - `clearFault` pulse returns to IDLE with `faultCode`=00.
- Opcode 5 with `unitDone` never asserted:
  - `unitEn` high exactly 15 cycles, then FAULT with `faultCode`=10.
  - Repeat with done arriving on the timeout cycle: retires, no fault.
- During EXEC of opcode 5, pulse `unitDone[3]`: ignored, state stays EXEC. Drop `run` mid-EXEC: instruction completes, GAP goes to IDLE.
- Preload `retired` to 16'hFFFF by running 65535 instructions (or forcing in the bench); one more instruction wraps `retired` to 0. Assert `rst` mid-EXEC: all outputs 0 the same cycle.
